bit_deserializer: RTL

- Upstream feeder for the priority-encoder stage: collects a serial bit stream into WIDTH-bit parallel words.
- Emits each word with a one-cycle valid pulse, matching the encoder's data_i/data_val_i contract.
- Supports early flush of a partial word with a bit-count tag.
- Flags stream errors (flush of an empty word, input while disabled) for debug.

---
 rtl/bit_deserializer_pkg.sv | 10 +
 rtl/deser_bit_counter.sv | 30 +++
 rtl/bit_deserializer.sv | 83 ++++++++
 3 files changed

// File: rtl/bit_deserializer_pkg.sv
// bit_deserializer_pkg: shared FSM state type and counter width helper for the deserializer.
package bit_deserializer_pkg;

    typedef enum logic {ST_IDLE, ST_FILL} state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/deser_bit_counter.sv
// deser_bit_counter: counts accepted bits of the current word; clr wins over inc.
module deser_bit_counter
    import bit_deserializer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         inc,
    input  logic                         clr,
    output logic [cnt_width(WIDTH)-1:0]  cnt,
    output logic                         full,
    output logic                         empty
);
    localparam int CW = cnt_width(WIDTH);

    always_comb begin
        full  = inc && (cnt == CW'(WIDTH - 1));
        empty = (cnt == '0);
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + CW'(1);

endmodule

// File: rtl/bit_deserializer.sv
// bit_deserializer: serial-to-parallel word assembler with flush and error pulses.
// Define BIT_DESERIALIZER_LSB_FIRST_EN to place the first bit at bit 0 instead of WIDTH-1.
module bit_deserializer
    import bit_deserializer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic                         data_i,
    input  logic                         data_val_i,
    input  logic                         flush_i,
    output logic [WIDTH-1:0]             deser_data_o,
    output logic [cnt_width(WIDTH)-1:0]  deser_len_o,
    output logic                         deser_data_val_o,
    output logic                         err_o
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] word_nxt;
    logic [WIDTH-1:0] mask;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    len_nxt;
    logic [CW-1:0]    pos;
    logic             acc;
    logic             full;
    logic             empty;
    logic             emit;
    logic             err;

    deser_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc   (acc),
        .clr   (emit),
        .cnt   (cnt),
        .full  (full),
        .empty (empty)
    );

    // A bit accepted alongside a flush is merged into the word before it is emitted.
    always_comb begin
        acc      = en_i & data_val_i;
`ifdef BIT_DESERIALIZER_LSB_FIRST_EN
        pos      = cnt;
`else
        pos      = CW'(WIDTH - 1) - cnt;
`endif
        mask     = WIDTH'(1) << pos;
        word_nxt = (acc && data_i) ? (shreg | mask) : shreg;
        len_nxt  = cnt + CW'(acc);
        emit     = full | (flush_i & (acc | ~empty));
        err      = (data_val_i & ~en_i) | (flush_i & ~acc & (state == ST_IDLE));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state            <= ST_IDLE;
            shreg            <= '0;
            deser_data_o     <= '0;
            deser_len_o      <= '0;
            deser_data_val_o <= 1'b0;
            err_o            <= 1'b0;
        end else begin
            deser_data_val_o <= emit;
            err_o            <= err;
            if (emit) begin
                deser_data_o <= word_nxt;
                deser_len_o  <= len_nxt;
                shreg        <= '0;
                state        <= ST_IDLE;
            end else begin
                shreg        <= word_nxt;
                if (acc)
                    state    <= ST_FILL;
            end
        end
    end

endmodule
